// File: rtl/sram_port_arbiter.sv
// ============================================================================
// sram_port_arbiter : N-channel arbiter onto one single-port SRAM, with a
//                     fixed-latency {valid,id,error} response pipeline.
// Revision 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int          NUM_CH   = 3,
    parameter int          RD_LAT   = 1,
    parameter int          RR_MODE  = 1,
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0001_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_CH-1:0]    ch_req_i,
    input  logic [NUM_CH*32-1:0] ch_addr_i,
    input  logic [NUM_CH*32-1:0] ch_wdata_i,
    input  logic [NUM_CH-1:0]    ch_we_i,
    input  logic [NUM_CH*4-1:0]  ch_be_i,
    output logic [NUM_CH-1:0]    ch_gnt_o,
    output logic [NUM_CH-1:0]    ch_ack_o,
    output logic [NUM_CH-1:0]    ch_error_o,
    output logic [NUM_CH*32-1:0] ch_rdata_o,
    output logic                 sram_req_o,
    output logic [31:0]          sram_addr_o,
    output logic [31:0]          sram_wdata_o,
    output logic                 sram_we_o,
    output logic [3:0]           sram_be_o,
    input  logic [31:0]          sram_rdata_i
);

    localparam int          PTR_W  = $clog2(NUM_CH);
    localparam logic [32:0] WIN_LO = {1'b0, MEM_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    logic [PTR_W-1:0]  ptr;
    logic              gnt_any;
    logic [PTR_W-1:0]  gnt_id;
    logic [31:0]       sel_addr;
    logic              sel_we;
    logic              in_win;

    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_err;
    logic [RD_LAT-1:0] pipe_we;
    logic [PTR_W-1:0]  pipe_id [RD_LAT];

    // Arbitration is suppressed in reset so nothing can reach the SRAM port.
    always_comb begin
        logic [PTR_W-1:0] cand;
        cand    = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (rst_ni) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cand = (RR_MODE != 0) ? PTR_W'((int'(ptr) + i) % NUM_CH) : PTR_W'(i);
                if (!gnt_any && ch_req_i[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
    end

    always_comb begin
        ch_gnt_o = '0;
        if (gnt_any) begin
            ch_gnt_o[gnt_id] = 1'b1;
        end
    end

    assign sel_addr = ch_addr_i[32*gnt_id +: 32];
    assign sel_we   = ch_we_i[gnt_id];
    // 33-bit compare so a window ending at 2^32 does not wrap to zero.
    assign in_win   = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI);

    assign sram_req_o   = gnt_any && in_win;
    assign sram_addr_o  = sram_req_o ? sel_addr : '0;
    assign sram_wdata_o = sram_req_o ? ch_wdata_i[32*gnt_id +: 32] : '0;
    assign sram_we_o    = sram_req_o && sel_we;
    assign sram_be_o    = sram_req_o ? ch_be_i[4*gnt_id +: 4] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr      <= '0;
            pipe_vld <= '0;
            pipe_err <= '0;
            pipe_we  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= gnt_any;
            pipe_id[0]  <= gnt_id;
            pipe_err[0] <= gnt_any && !in_win;
            pipe_we[0]  <= gnt_any && sel_we;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
                pipe_err[i] <= pipe_err[i-1];
                pipe_we[i]  <= pipe_we[i-1];
            end
            if ((RR_MODE != 0) && gnt_any) begin
                ptr <= (gnt_id == PTR_W'(NUM_CH - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    // Read data is only meaningful for a successful read in its ack cycle.
    always_comb begin
        ch_ack_o   = '0;
        ch_error_o = '0;
        ch_rdata_o = '0;
        if (pipe_vld[RD_LAT-1]) begin
            ch_ack_o[pipe_id[RD_LAT-1]]   = 1'b1;
            ch_error_o[pipe_id[RD_LAT-1]] = pipe_err[RD_LAT-1];
            if (!pipe_err[RD_LAT-1] && !pipe_we[RD_LAT-1]) begin
                ch_rdata_o[32*pipe_id[RD_LAT-1] +: 32] = sram_rdata_i;
            end
        end
    end

endmodule

`default_nettype wire
